mem_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 28 ++
 rtl/arb_wdog.sv | 33 +++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
//   arb_state_t : arbiter FSM state (3-bit encoding, exported on dbg_state)
//   arb_src_t   : which requester received the most recent grant
//   DEF_ADDR_W / DEF_DATA_W : default bus widths
package arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_D   = 3'd1,
    ST_REQ_I   = 3'd2,
    ST_WAIT_D  = 3'd3,
    ST_WAIT_I  = 3'd4,
    ST_WAIT_IK = 3'd5   // fetch killed, memory response still owed
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

  function automatic logic is_wait(input arb_state_t s);
    return (s == ST_WAIT_D) || (s == ST_WAIT_I) || (s == ST_WAIT_IK);
  endfunction

endpackage

// File: rtl/arb_wdog.sv
// Response watchdog for the arbiter's WAIT states.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : zero the count (asserted on the cycle that enters a WAIT state)
//   en       : count this cycle (high while in a WAIT state)
//   expire   : high during the TIMEOUT_CYC-th consecutive enabled cycle
module arb_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // First WAIT cycle sees cnt == 0, so the TIMEOUT_CYC-th one sees TIMEOUT_CYC-1.
  assign expire = en && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch (read
// only) and the MEM stage (load/store). One transaction is in flight at a time.
//
// Handshakes (all level/pulse, sampled at posedge clk):
//   if_req / d_req : held high by the requester until its *_valid pulse.
//   if_valid / d_valid : one-cycle completion pulse; never both in a cycle.
//   m_req with m_we/m_addr/m_wdata/m_be : command, held stable until m_gnt.
//   m_gnt : memory took the command this cycle.
//   m_rvalid with m_rdata : response (read data or write ack), one cycle,
//           only meaningful in a WAIT state.
//   if_kill : redirect; the current fetch's response is discarded.
//   bus_err : sticky, set when the watchdog force-completes a transaction.
//   dbg_state : current arb_state_t encoding.
// Reset rst is asynchronous, active low.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_be,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              bus_err,
  output logic [2:0]        dbg_state
);

  arb_state_t state;
  arb_src_t   last_src;
  logic       kill_pend;

  logic pend_i;
  logic pend_d;
  logic pick_d;
  logic kill_now;
  logic wait_enter;
  logic in_wait;
  logic wd_expire;

  assign dbg_state = state;

  always_comb begin
    // A requester whose valid is high this cycle is just finishing; its
    // request line has not dropped yet.
    pend_i     = if_req && !if_valid;
    pend_d     = d_req && !d_valid;
    pick_d     = pend_d && (!pend_i || (last_src == SRC_I));
    kill_now   = if_kill && if_req;
    in_wait    = is_wait(state);
    wait_enter = (((state == ST_REQ_D) || (state == ST_REQ_I)) && m_gnt) ||
                 ((state == ST_WAIT_I) && if_kill && !m_rvalid);
  end

  arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_enter),
    .en     (in_wait),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      last_src  <= SRC_I;   // no history: data wins the first tie
      kill_pend <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_be      <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            state    <= ST_REQ_D;
            last_src <= SRC_D;
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            m_be     <= d_be;
          end else if (pend_i) begin
            state     <= ST_REQ_I;
            last_src  <= SRC_I;
            kill_pend <= 1'b0;
            m_req     <= 1'b1;
            m_we      <= 1'b0;
            m_addr    <= if_addr;
            m_wdata   <= '0;
            m_be      <= 4'hF;
          end
        end

        ST_REQ_D: begin
          if (m_gnt) begin
            m_req <= 1'b0;
            state <= ST_WAIT_D;
          end
        end

        ST_REQ_I: begin
          // An issued command cannot be withdrawn; remember the kill so the
          // response is dropped once it arrives.
          if (m_gnt) begin
            m_req     <= 1'b0;
            kill_pend <= 1'b0;
            state     <= (kill_pend || kill_now) ? ST_WAIT_IK : ST_WAIT_I;
          end else if (kill_now) begin
            kill_pend <= 1'b1;
          end
        end

        ST_WAIT_D: begin
          if (m_rvalid) begin
            d_valid <= 1'b1;
            if (!m_we) d_rdata <= m_rdata;  // store acks leave d_rdata alone
            state <= ST_IDLE;
          end else if (wd_expire) begin
            d_valid <= 1'b1;
            d_rdata <= '0;
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        ST_WAIT_I: begin
          if (m_rvalid) begin
            if (!if_kill) begin
              if_valid <= 1'b1;
              if_rdata <= m_rdata;
            end
            state <= ST_IDLE;
          end else if (if_kill) begin
            state <= ST_WAIT_IK;
          end else if (wd_expire) begin
            if_valid <= 1'b1;
            if_rdata <= '0;
            bus_err  <= 1'b1;
            state    <= ST_IDLE;
          end
        end

        ST_WAIT_IK: begin
          if (m_rvalid) begin
            state <= ST_IDLE;
          end else if (wd_expire) begin
            bus_err <= 1'b1;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory must not answer in the same cycle it grants.
  a_no_gnt_rvalid: assert property (@(posedge clk) disable iff (!rst)
    (((state == ST_REQ_D) || (state == ST_REQ_I)) && m_gnt) |-> !m_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          if_req, if_kill, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_valid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [3:0]    d_be;
  logic          m_req, m_we, m_gnt, m_rvalid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [3:0]    m_be;
  logic          bus_err;
  logic [2:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;
  int d_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];
  logic [DW-1:0] last_d_exp = '0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_val(a);
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] exp_i_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (if_valid && d_valid) chk("dual_valid", 1, 0);
      if (d_valid) begin
        d_pulses++;
        if (exp_d_q.size() == 0) chk("d_valid_unexpected", 1, 0);
        else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
      if (if_valid) begin
        if (exp_i_q.size() == 0) chk("if_valid_unexpected", 1, 0);
        else chk("if_rdata", if_rdata, exp_i_q.pop_front());
      end
    end
  end

  // ---------------- memory environment ----------------
  int  gnt_lo = 0, gnt_hi = 0, rsp_lo = 0, rsp_hi = 0;
  bit  drop_rsp = 0, mem_manual = 0, chk_stable = 0;
  int  req_cycles = 0;
  logic [31:0] cmd_addr_q[$];

  initial begin : mem_model
    bit          in_req, rsp_pend, rsp_we;
    int          wait_left, rsp_left;
    logic [68:0] snap;
    logic [31:0] rd_val;
    in_req = 0; rsp_pend = 0; rsp_we = 0; wait_left = 0; rsp_left = 0;
    snap = '0; rd_val = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!mem_manual) begin
        m_gnt = 0; m_rvalid = 0; m_rdata = '0;
        if (!rst) begin
          in_req = 0; rsp_pend = 0;
        end else if (rsp_pend) begin
          if (rsp_left == 0) begin
            m_rvalid = 1;
            m_rdata  = rsp_we ? $urandom : rd_val;
            rsp_pend = 0;
          end else rsp_left--;
        end else if (m_req) begin
          if (!in_req) begin
            in_req = 1;
            wait_left = $urandom_range(gnt_hi, gnt_lo);
            snap = {m_we, m_addr, m_wdata, m_be};
            req_cycles = 0;
          end else if (chk_stable) begin
            chk("cmd_stable", {m_we, m_addr, m_wdata, m_be}, snap);
          end
          req_cycles++;
          if (wait_left == 0) begin
            m_gnt = 1; in_req = 0;
            cmd_addr_q.push_back(m_addr);
            rsp_we = m_we;
            if (m_we) env_mem[m_addr] = merge(env_read(m_addr), m_wdata, m_be);
            else rd_val = env_read(m_addr);
            rsp_left = $urandom_range(rsp_hi, rsp_lo);
            rsp_pend = !drop_rsp;
          end else wait_left--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic data_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit exp_to, output int lat);
    logic [DW-1:0] e;
    int start, n;
    @(posedge clk); #1;
    d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    start = cyc;
    if (exp_to) e = '0;
    else if (we) e = last_d_exp;
    else e = ref_read(addr);
    if (we) ref_mem[addr] = merge(ref_read(addr), wdata, be);
    last_d_exp = e;
    exp_d_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_valid && n < 200);
    if (!d_valid) chk("d_valid_timeout", 0, 1);
    lat = cyc - start;
    @(posedge clk); #1;
    d_req = 0;
  endtask

  task automatic fetch_op(input logic [31:0] addr);
    int n;
    @(posedge clk); #1;
    if_req = 1; if_addr = addr;
    exp_i_q.push_back(ref_read(addr));
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid && n < 200);
    if (!if_valid) chk("if_valid_timeout", 0, 1);
    @(posedge clk); #1;
    if_req = 0;
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int lat, p0;
    logic [31:0] a;
    if_req = 0; if_addr = '0; if_kill = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = 4'hF;

    // reset state
    #1;
    chk("rst_outputs_zero", |{m_req, m_we, m_addr, m_wdata, m_be, if_rdata, if_valid,
                              d_rdata, d_valid, bus_err}, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    repeat (2) @(posedge clk);
    #2 rst = 1;

    // contention after reset: data first, then fetch
    cmd_addr_q.delete();
    fork
      data_op(0, 32'h1000_0010, 0, 4'hF, 0, lat);
      fetch_op(32'h0000_2010);
    join
    chk("pair1_count", cmd_addr_q.size(), 2);
    if (cmd_addr_q.size() >= 2) begin
      chk("pair1_first_is_data", cmd_addr_q[0], 32'h1000_0010);
      chk("pair1_second_is_fetch", cmd_addr_q[1], 32'h0000_2010);
    end

    // load only, zero-wait memory: 3-cycle latency
    env_mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    data_op(0, 32'h100, 0, 4'hF, 0, lat);
    chk("load_latency", lat, 3);

    // contention with last grant = data: fetch first
    cmd_addr_q.delete();
    fork
      data_op(0, 32'h1000_0020, 0, 4'hF, 0, lat);
      fetch_op(32'h0000_2020);
    join
    chk("pair2_count", cmd_addr_q.size(), 2);
    if (cmd_addr_q.size() >= 2) begin
      chk("pair2_first_is_fetch", cmd_addr_q[0], 32'h0000_2020);
      chk("pair2_second_is_data", cmd_addr_q[1], 32'h1000_0020);
    end

    // kill in WAIT_I, two cycles before the response
    env_mem[32'h0000_3000] = 32'h0000_0013;
    rsp_lo = 3; rsp_hi = 3;
    @(posedge clk); #1;
    if_req = 1; if_addr = 32'h0000_3000;
    repeat (3) @(posedge clk);
    #1;
    if_kill = 1; if_addr = 32'h0000_3400;
    exp_i_q.push_back(ref_read(32'h0000_3400));
    @(posedge clk); #1;
    if_kill = 0;
    rsp_lo = 0; rsp_hi = 0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("kill_idle_after_rvalid", dbg_state, ST_IDLE);
    chk("kill_no_if_valid", if_valid, 0);
    p0 = 0;
    while (!if_valid && p0 < 50) begin @(negedge clk); p0++; end
    chk("redirect_fetch_done", if_valid, 1);
    @(posedge clk); #1;
    if_req = 0;

    // backpressure: grant held off 5 cycles, partial store then readback
    gnt_lo = 5; gnt_hi = 5; chk_stable = 1;
    data_op(1, 32'h1000_0080, 32'hAABB_CCDD, 4'b0011, 0, lat);
    chk_stable = 0;
    chk("bp_req_cycles", req_cycles, 6);
    gnt_lo = 0; gnt_hi = 0;
    data_op(0, 32'h1000_0080, 0, 4'hF, 0, lat);

    // timeout
    drop_rsp = 1;
    data_op(0, 32'h1000_0090, 0, 4'hF, 1, lat);
    chk("timeout_latency", lat, TO + 2);
    chk("timeout_bus_err", bus_err, 1);
    drop_rsp = 0;
    data_op(0, 32'h1000_0094, 0, 4'hF, 0, lat);
    chk("bus_err_sticky", bus_err, 1);

    // async reset mid-WAIT_D
    drop_rsp = 1;
    @(posedge clk); #1;
    d_req = 1; d_we = 0; d_addr = 32'h1000_00A0;
    repeat (3) @(posedge clk);
    #3;
    rst = 0; d_req = 0;
    #1;
    chk("midrst_outputs_zero", |{m_req, m_we, m_addr, m_wdata, m_be, if_rdata, if_valid,
                                 d_rdata, d_valid, bus_err}, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    exp_d_q.delete();
    last_d_exp = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    mem_manual = 1; p0 = d_pulses;
    @(posedge clk); #1;
    m_rvalid = 1; m_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    m_rvalid = 0; m_rdata = '0;
    mem_manual = 0; drop_rsp = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_no_d_valid", d_pulses - p0, 0);
    chk("rst_idle", dbg_state, ST_IDLE);
    data_op(0, 32'h1000_00A0, 0, 4'hF, 0, lat);
    chk("post_rst_latency", lat, 3);

    // randomized concurrent traffic
    gnt_lo = 0; gnt_hi = 3; rsp_lo = 0; rsp_hi = 4;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          a = 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4;
          if ($urandom_range(0, 1) == 1)
            data_op(1, a, $urandom, 4'($urandom_range(1, 15)), 0, lat);
          else
            data_op(0, a, 0, 4'hF, 0, lat);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          fetch_op(32'h0000_2000 + 32'($urandom_range(0, 63)) * 4);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join

    repeat (5) @(posedge clk);
    chk("d_queue_empty", exp_d_q.size(), 0);
    chk("i_queue_empty", exp_i_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
